reg_file_sb: RTL and testbench

- General-purpose register file with an integrated pending-write scoreboard.
- Sits at the far end of the decode→execute write-intent path.
  - Writeback delivers write_enable/write_addr/data here.
  - Decode reads both operands here and gets a per-operand busy flag for stall decisions.
  - Decode declares each issued destination register here, so later readers know a write is still in flight.

---
 rtl/reg_file_sb_pkg.sv | 31 +++
 rtl/reg_file_sb_counter.sv | 39 +++
 rtl/reg_file_sb.sv | 101 ++++++++++
 tb/tb_reg_file_sb.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_sb_pkg.sv
// Shared widths, bus types and constants for the register file and its pending-write scoreboard.
package reg_file_sb_pkg;

  localparam int REG_BUS_W  = 32;
  localparam int REG_ADDR_W = 5;
  localparam int REG_NUM    = 32;
  localparam int SB_CNT_W   = 2;

  typedef logic [REG_BUS_W-1:0]  reg_bus;
  typedef logic [REG_ADDR_W-1:0] reg_addr_bus;
  typedef logic [SB_CNT_W-1:0]   sb_cnt_bus;

  localparam logic   rst_enable = 1'b1;
  localparam reg_bus zero_v     = '0;
  localparam logic   false_v    = 1'b0;
  localparam logic   true_v     = 1'b1;

  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_INC  = 2'd1,
    CNT_DEC  = 2'd2
  } cnt_op_e;

  // A simultaneous increment and decrement cancel out.
  function automatic cnt_op_e cnt_op(input logic inc, input logic dec);
    if (inc && !dec) return CNT_INC;
    if (dec && !inc) return CNT_DEC;
    return CNT_HOLD;
  endfunction

endpackage

// File: rtl/reg_file_sb_counter.sv
// One per-register pending-write counter: up/down, refusing to wrap in either direction.
module sb_counter
  import reg_file_sb_pkg::*;
#(
  parameter int CNT_W = SB_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             sat_o,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  cnt_op_e          op;

  assign sat_o  = &cnt_q;
  assign zero_o = (cnt_q == '0);
  assign cnt_o  = cnt_q;

  always_comb begin
    op    = cnt_op(inc_i, dec_i);
    cnt_d = cnt_q;
    case (op)
      CNT_INC:  if (!sat_o)  cnt_d = cnt_q + CNT_W'(1);
      CNT_DEC:  if (!zero_o) cnt_d = cnt_q - CNT_W'(1);
      default:  cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == rst_enable) cnt_q <= '0;
    else                   cnt_q <= cnt_d;
  end

endmodule

// File: rtl/reg_file_sb.sv
// Register file with same-cycle write bypass and a per-register scoreboard of in-flight writes,
// giving decode a busy flag per operand and back-pressure on destination issue.
module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter int DATA_W   = REG_BUS_W,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int NUM_REGS = REG_NUM,
  parameter int CNT_W    = SB_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic              read_enable_1,
  input  logic [ADDR_W-1:0] read_addr_1,
  output logic [DATA_W-1:0] read_data_1,
  output logic              read_busy_1,
  input  logic              read_enable_2,
  input  logic [ADDR_W-1:0] read_addr_2,
  output logic [DATA_W-1:0] read_data_2,
  output logic              read_busy_2,
  input  logic              issue_enable,
  input  logic [ADDR_W-1:0] issue_addr,
  output logic              issue_ready,
  output logic              pending_any
);

  logic [DATA_W-1:0]                regs_q [NUM_REGS];
  logic [NUM_REGS-1:0][CNT_W-1:0]   cnt_vec;
  logic [NUM_REGS-1:0]              sat_vec;
  logic [NUM_REGS-1:0]              zero_vec;
  logic                             issue_acc;
  logic                             write_live;

  assign write_live = write_enable && (write_addr != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst == rst_enable) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (write_live) begin
      regs_q[write_addr] <= write_data;
    end
  end

  // Register 0 never tracks anything, so its counter is a constant.
  assign cnt_vec[0]  = '0;
  assign sat_vec[0]  = false_v;
  assign zero_vec[0] = true_v;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
    logic inc;
    logic dec;
    assign inc = issue_acc && (issue_addr == ADDR_W'(r));
    assign dec = write_enable && (write_addr == ADDR_W'(r));
    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .inc_i  (inc),
      .dec_i  (dec),
      .cnt_o  (cnt_vec[r]),
      .sat_o  (sat_vec[r]),
      .zero_o (zero_vec[r])
    );
  end

  // A write landing on a full destination frees a slot in the same cycle.
  assign issue_ready = (issue_addr == '0) || !sat_vec[issue_addr] ||
                       (write_enable && (write_addr == issue_addr));
  assign issue_acc   = issue_enable && issue_ready && (issue_addr != '0);
  assign pending_any = ~&zero_vec;

  // Busy drops only when this cycle's write retires the last outstanding result.
  always_comb begin
    read_data_1 = zero_v[DATA_W-1:0];
    read_busy_1 = false_v;
    if (read_enable_1 && (read_addr_1 != '0)) begin
      read_data_1 = (write_enable && (write_addr == read_addr_1)) ? write_data
                                                                   : regs_q[read_addr_1];
      read_busy_1 = !zero_vec[read_addr_1] &&
                    !(write_enable && (write_addr == read_addr_1) &&
                      (cnt_vec[read_addr_1] == CNT_W'(1)) &&
                      !(issue_acc && (issue_addr == read_addr_1)));
    end
  end

  always_comb begin
    read_data_2 = zero_v[DATA_W-1:0];
    read_busy_2 = false_v;
    if (read_enable_2 && (read_addr_2 != '0)) begin
      read_data_2 = (write_enable && (write_addr == read_addr_2)) ? write_data
                                                                   : regs_q[read_addr_2];
      read_busy_2 = !zero_vec[read_addr_2] &&
                    !(write_enable && (write_addr == read_addr_2) &&
                      (cnt_vec[read_addr_2] == CNT_W'(1)) &&
                      !(issue_acc && (issue_addr == read_addr_2)));
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_reg_file_sb;

  logic        clk;
  logic        rst;
  logic        write_enable;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic        read_enable_1;
  logic [4:0]  read_addr_1;
  logic [31:0] read_data_1;
  logic        read_busy_1;
  logic        read_enable_2;
  logic [4:0]  read_addr_2;
  logic [31:0] read_data_2;
  logic        read_busy_2;
  logic        issue_enable;
  logic [4:0]  issue_addr;
  logic        issue_ready;
  logic        pending_any;

  int          passCount;
  int          totalCount;
  bit          cmpOn;

  int unsigned modelReg [32];
  int          modelCnt [32];

  reg_file_sb dut (
    .clk           (clk),
    .rst           (rst),
    .write_enable  (write_enable),
    .write_addr    (write_addr),
    .write_data    (write_data),
    .read_enable_1 (read_enable_1),
    .read_addr_1   (read_addr_1),
    .read_data_1   (read_data_1),
    .read_busy_1   (read_busy_1),
    .read_enable_2 (read_enable_2),
    .read_addr_2   (read_addr_2),
    .read_data_2   (read_data_2),
    .read_busy_2   (read_busy_2),
    .issue_enable  (issue_enable),
    .issue_addr    (issue_addr),
    .issue_ready   (issue_ready),
    .pending_any   (pending_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: spec-level answers from the current inputs and model state.
  function automatic bit expReady();
    if (issue_addr == 0) return 1'b1;
    if (modelCnt[issue_addr] < 3) return 1'b1;
    return write_enable && (write_addr == issue_addr);
  endfunction

  function automatic bit issueTaken(input int a);
    return issue_enable && expReady() && (issue_addr != 0) && (issue_addr == a);
  endfunction

  function automatic logic [31:0] expData(input logic en, input logic [4:0] a);
    if (!en || a == 0) return 32'h0;
    if (write_enable && write_addr == a) return write_data;
    return modelReg[a];
  endfunction

  function automatic logic expBusy(input logic en, input logic [4:0] a);
    int after;
    if (!en || a == 0) return 1'b0;
    if (modelCnt[a] == 0) return 1'b0;
    after = modelCnt[a];
    if (write_enable && write_addr == a && !issueTaken(a)) after = after - 1;
    return after != 0;
  endfunction

  function automatic logic expPending();
    for (int r = 0; r < 32; r++) if (modelCnt[r] != 0) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 32; r++) begin
        modelReg[r] = 0;
        modelCnt[r] = 0;
      end
    end else begin
      int  ia;
      int  wa;
      bit  took;
      ia   = issue_addr;
      wa   = write_addr;
      took = issue_enable && expReady() && (ia != 0);
      if (write_enable && wa != 0) modelReg[wa] = write_data;
      if (took && !(write_enable && wa == ia)) modelCnt[ia] = modelCnt[ia] + 1;
      if (write_enable && wa != 0 && !(took && ia == wa) && modelCnt[wa] > 0)
        modelCnt[wa] = modelCnt[wa] - 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    totalCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
  endtask

  always @(negedge clk) begin
    if (cmpOn) begin
      checkOutput("cmp_rd1",     read_data_1, expData(read_enable_1, read_addr_1));
      checkOutput("cmp_rd2",     read_data_2, expData(read_enable_2, read_addr_2));
      checkOutput("cmp_busy1",   32'(read_busy_1), 32'(expBusy(read_enable_1, read_addr_1)));
      checkOutput("cmp_busy2",   32'(read_busy_2), 32'(expBusy(read_enable_2, read_addr_2)));
      checkOutput("cmp_ready",   32'(issue_ready), 32'(expReady()));
      checkOutput("cmp_pending", 32'(pending_any), 32'(expPending()));
    end
  end

  task automatic applyStimulus(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                               input logic r1e, input logic [4:0] r1a,
                               input logic r2e, input logic [4:0] r2a,
                               input logic ie, input logic [4:0] ia);
    @(posedge clk);
    #1;
    write_enable  = we;
    write_addr    = wa;
    write_data    = wd;
    read_enable_1 = r1e;
    read_addr_1   = r1a;
    read_enable_2 = r2e;
    read_addr_2   = r2a;
    issue_enable  = ie;
    issue_addr    = ia;
    #3;
  endtask

  initial begin
    logic        we, r1e, r2e, ie;
    logic [4:0]  wa, r1a, r2a, ia;
    logic [31:0] wd;
    passCount     = 0;
    totalCount    = 0;
    cmpOn         = 1'b0;
    rst           = 1'b1;
    write_enable  = 1'b0;
    write_addr    = '0;
    write_data    = '0;
    read_enable_1 = 1'b0;
    read_addr_1   = '0;
    read_enable_2 = 1'b0;
    read_addr_2   = '0;
    issue_enable  = 1'b0;
    issue_addr    = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    cmpOn = 1'b1;

    applyStimulus(0, 0, 0, 1, 5, 0, 0, 0, 0);
    checkOutput("reset_rd1", read_data_1, 32'h0);
    checkOutput("reset_ready", 32'(issue_ready), 32'd1);
    checkOutput("reset_pending", 32'(pending_any), 32'd0);

    // Asynchronous reset wipes a written value with no clock edge.
    applyStimulus(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 5, 0, 0, 0, 0);
    checkOutput("r5_written", read_data_1, 32'hDEADBEEF);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_async_rd1", read_data_1, 32'h0);
    checkOutput("rst_async_pending", 32'(pending_any), 32'd0);
    #1 rst = 1'b0;
    applyStimulus(0, 0, 0, 1, 5, 0, 0, 0, 0);
    checkOutput("rst_after_rd1", read_data_1, 32'h0);
    checkOutput("rst_after_pending", 32'(pending_any), 32'd0);

    applyStimulus(1, 0, 32'h12345678, 1, 0, 1, 0, 0, 0);
    checkOutput("r0_rd1", read_data_1, 32'h0);
    checkOutput("r0_rd2", read_data_2, 32'h0);
    checkOutput("r0_busy1", 32'(read_busy_1), 32'd0);
    checkOutput("r0_busy2", 32'(read_busy_2), 32'd0);

    applyStimulus(1, 7, 32'h11, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 7, 32'h22, 0, 0, 1, 7, 0, 0);
    checkOutput("bypass_rd2", read_data_2, 32'h22);
    applyStimulus(0, 0, 0, 0, 0, 1, 7, 0, 0);
    checkOutput("bypass_held_rd2", read_data_2, 32'h22);

    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 3);
    checkOutput("sb3_ready", 32'(issue_ready), 32'd1);
    applyStimulus(0, 0, 0, 1, 3, 0, 0, 0, 0);
    checkOutput("sb3_busy", 32'(read_busy_1), 32'd1);
    checkOutput("sb3_pending", 32'(pending_any), 32'd1);
    applyStimulus(1, 3, 32'h5A, 1, 3, 0, 0, 0, 0);
    checkOutput("sb3_wr_busy", 32'(read_busy_1), 32'd0);
    checkOutput("sb3_wr_rd1", read_data_1, 32'h5A);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("sb3_clear_pending", 32'(pending_any), 32'd0);

    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 9);
      checkOutput("sat_fill_ready", 32'(issue_ready), 32'd1);
    end
    applyStimulus(0, 0, 0, 1, 9, 0, 0, 1, 9);
    checkOutput("sat_ready", 32'(issue_ready), 32'd0);
    applyStimulus(1, 9, 32'h77, 1, 9, 0, 0, 0, 9);
    checkOutput("sat_wr_busy", 32'(read_busy_1), 32'd1);
    applyStimulus(0, 0, 0, 1, 9, 0, 0, 0, 9);
    checkOutput("sat_after_ready", 32'(issue_ready), 32'd1);
    checkOutput("sat_after_busy", 32'(read_busy_1), 32'd1);
    applyStimulus(1, 9, 32'h78, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 9, 32'h79, 1, 9, 0, 0, 0, 0);
    checkOutput("sat_last_busy", 32'(read_busy_1), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("sat_drained", 32'(pending_any), 32'd0);

    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 4);
    applyStimulus(1, 4, 32'h99, 0, 0, 0, 0, 1, 4);
    checkOutput("simul_ready", 32'(issue_ready), 32'd1);
    applyStimulus(0, 0, 0, 1, 4, 0, 0, 0, 0);
    checkOutput("simul_busy", 32'(read_busy_1), 32'd1);
    checkOutput("simul_rd1", read_data_1, 32'h99);
    applyStimulus(1, 12, 32'h44, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 12, 1, 4, 0, 0);
    checkOutput("untracked_busy", 32'(read_busy_1), 32'd0);
    checkOutput("untracked_rd1", read_data_1, 32'h44);
    checkOutput("simul_busy2", 32'(read_busy_2), 32'd1);
    applyStimulus(1, 4, 32'hAB, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("simul_drained", 32'(pending_any), 32'd0);

    // Random traffic on a narrow address window so counters collide and saturate.
    for (int i = 0; i < 3000; i++) begin
      we  = ($urandom_range(0, 2) == 0);
      ie  = ($urandom_range(0, 1) == 1);
      r1e = ($urandom_range(0, 3) != 0);
      r2e = ($urandom_range(0, 3) != 0);
      wa  = 5'($urandom_range(0, 7) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 7));
      ia  = 5'($urandom_range(0, 7) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 7));
      r1a = 5'($urandom_range(0, 7));
      r2a = 5'($urandom_range(0, 7));
      wd  = $urandom;
      applyStimulus(we, wa, wd, r1e, r1a, r2e, r2a, ie, ia);
    end

    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 cmpOn = 1'b0;
    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
